// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared widths, FSM state encoding and ALU control codes for alu_share_arbiter
package alu_arb_pkg;
  localparam int XLEN_DEF = 32;
  localparam int CTRW_DEF = 4;
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b1010;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: 2-way combinational round-robin; ports valid[1:0], last (previous winner) -> grant[1:0] one-hot or zero
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic [1:0] grant
);
  always_comb grant = &valid ? (last ? 2'b01 : 2'b10) : valid;
endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one external ALU between two valid/ready ports (req_*/rsp_* per port, alu_* to/from ALU); ALU_ARB_PERF_EN adds perf_grant0/perf_grant1/perf_conflict
module alu_share_arbiter
  import alu_arb_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int CTRW = CTRW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [1:0][XLEN-1:0] req_a,
  input  logic [1:0][XLEN-1:0] req_b,
  input  logic [1:0][CTRW-1:0] req_ctr,
  output logic [1:0]           rsp_valid,
  input  logic [1:0]           rsp_ready,
  output logic [XLEN-1:0]      rsp_out,
  output logic                 rsp_less,
  output logic                 rsp_zero,
  output logic [XLEN-1:0]      alu_a,
  output logic [XLEN-1:0]      alu_b,
  output logic [CTRW-1:0]      alu_ctr,
  input  logic [XLEN-1:0]      alu_out,
  input  logic                 alu_less,
  input  logic                 alu_zero
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [31:0]          perf_grant0,
  output logic [31:0]          perf_grant1,
  output logic [31:0]          perf_conflict
`endif
);
  state_e state_q, state_d;
  logic last_q, last_d, own_q, own_d, acc;
  logic [1:0] grant;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [CTRW-1:0] ctr_q, ctr_d;
  logic less_q, less_d, zero_q, zero_d;
  rr_arb2 u_arb (.valid(req_valid), .last(last_q), .grant(grant));
  always_comb begin
    req_ready = state_q == IDLE ? grant : 2'b00;
    acc       = |(req_valid & req_ready);
    own_d     = acc ? grant[1] : own_q;
    last_d    = acc ? grant[1] : last_q;
    a_d       = acc ? req_a[grant[1]] : a_q;
    b_d       = acc ? req_b[grant[1]] : b_q;
    ctr_d     = acc ? req_ctr[grant[1]] : ctr_q;
    res_d     = state_q == ISSUE ? alu_out : res_q;
    less_d    = state_q == ISSUE ? alu_less : less_q;
    zero_d    = state_q == ISSUE ? alu_zero : zero_q;
    rsp_valid = state_q == RESP ? (own_q ? 2'b10 : 2'b01) : 2'b00;
    state_d   = state_q == IDLE  ? (acc ? ISSUE : IDLE) :
                state_q == ISSUE ? RESP :
                state_q == RESP  ? (rsp_ready[own_q] ? IDLE : RESP) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      own_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      ctr_q   <= '0;
      res_q   <= '0;
      less_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      own_q   <= own_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ctr_q   <= ctr_d;
      res_q   <= res_d;
      less_q  <= less_d;
      zero_q  <= zero_d;
    end
  end
  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign alu_ctr  = ctr_q;
  assign rsp_out  = res_q;
  assign rsp_less = less_q;
  assign rsp_zero = zero_q;
`ifdef ALU_ARB_PERF_EN
  logic [31:0] g0_q, g0_d, g1_q, g1_d, conf_q, conf_d;
  always_comb begin
    g0_d   = acc && !grant[1] ? g0_q + 32'd1 : g0_q;
    g1_d   = acc && grant[1] ? g1_q + 32'd1 : g1_q;
    conf_d = state_q == IDLE && &req_valid ? conf_q + 32'd1 : conf_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      g0_q   <= '0;
      g1_q   <= '0;
      conf_q <= '0;
    end else begin
      g0_q   <= g0_d;
      g1_q   <= g1_d;
      conf_q <= conf_d;
    end
  end
  assign perf_grant0   = g0_q;
  assign perf_grant1   = g1_q;
  assign perf_conflict = conf_q;
`endif
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed bench with a behavioural ALU and hand-computed expected results
module tb_alu_share_arbiter;
  import alu_arb_pkg::*;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [1:0][31:0] req_a, req_b;
  logic [1:0][3:0] req_ctr;
  logic [31:0] rsp_out, alu_a, alu_b, alu_out;
  logic rsp_less, rsp_zero, alu_less, alu_zero;
  logic [3:0] alu_ctr;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  alu_share_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_ctr(req_ctr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_out(rsp_out), .rsp_less(rsp_less), .rsp_zero(rsp_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctr(alu_ctr),
    .alu_out(alu_out), .alu_less(alu_less), .alu_zero(alu_zero)
  );
  always_comb begin
    alu_less = alu_ctr == ALU_SLTU ? alu_a < alu_b : $signed(alu_a) < $signed(alu_b);
    alu_out  = alu_ctr == ALU_ADD ? alu_a + alu_b :
               alu_ctr == ALU_SUB ? alu_a - alu_b :
               alu_ctr == ALU_SLT || alu_ctr == ALU_SLTU ? {31'd0, alu_less} :
               alu_ctr == ALU_XOR ? alu_a ^ alu_b :
               alu_ctr == ALU_OR  ? alu_a | alu_b :
               alu_ctr == ALU_AND ? alu_a & alu_b : 32'd0;
    alu_zero = alu_out == 32'd0;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic txn(input int p, input logic [31:0] eo, input logic el, input logic ez);
    #1 chk("grant", 32'(req_ready), p == 1 ? 32'd2 : 32'd1);
    @(negedge clk);
    chk("issue_rdy", 32'(req_ready), 32'd0);
    chk("alu_a", alu_a, req_a[p]);
    chk("alu_b", alu_b, req_b[p]);
    chk("alu_ctr", 32'(alu_ctr), 32'(req_ctr[p]));
    @(negedge clk);
    chk("rsp_valid", 32'(rsp_valid), p == 1 ? 32'd2 : 32'd1);
    chk("rsp_out", rsp_out, eo);
    chk("rsp_less", 32'(rsp_less), 32'(el));
    chk("rsp_zero", 32'(rsp_zero), 32'(ez));
    chk("alu_hold", alu_a, req_a[p]);
    @(negedge clk);
  endtask
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    rst = 1'b1;
    req_valid = 2'b00;
    req_a = '0;
    req_b = '0;
    req_ctr = '0;
    rsp_ready = 2'b11;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_out", rsp_out, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    req_valid = 2'b01;
    req_a[0] = 32'd5;
    req_b[0] = 32'd3;
    req_ctr[0] = ALU_ADD;
    txn(0, 32'd8, 1'b0, 1'b0);
    req_valid = 2'b00;
    @(negedge clk);
    chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("idle_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req_a[0] = 32'd7;
    req_b[0] = 32'd7;
    req_ctr[0] = ALU_SUB;
    req_a[1] = 32'hFFFF_FFFF;
    req_b[1] = 32'd1;
    req_ctr[1] = ALU_SLT;
    req_valid = 2'b11;
    for (int i = 0; i < 3; i++) begin
      txn(0, 32'd0, 1'b0, 1'b1);
      txn(1, 32'd1, 1'b1, 1'b0);
    end
    req_valid = 2'b00;
    @(negedge clk);
    req_valid = 2'b01;
    req_a[0] = 32'd10;
    req_b[0] = 32'd20;
    req_ctr[0] = ALU_ADD;
    rsp_ready = 2'b00;
    #1 chk("stall_grant", 32'(req_ready), 32'd1);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 32'(rsp_valid), 32'd1);
      chk("stall_out", rsp_out, 32'd30);
      chk("stall_rdy", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 2'b01;
    @(negedge clk);
    chk("release_valid", 32'(rsp_valid), 32'd0);
    #1 chk("release_rdy", 32'(req_ready), 32'd1);
    req_valid = 2'b00;
    @(negedge clk);
    req_valid = 2'b10;
    req_a[1] = 32'd1;
    req_b[1] = 32'hFFFF_FFFF;
    req_ctr[1] = ALU_SLTU;
    #1 chk("p1_grant", 32'(req_ready), 32'd2);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("nonown_valid", 32'(rsp_valid), 32'd2);
      chk("nonown_out", rsp_out, 32'd1);
      chk("nonown_less", 32'(rsp_less), 32'd1);
      @(negedge clk);
    end
    rsp_ready = 2'b10;
    @(negedge clk);
    chk("nonown_done", 32'(rsp_valid), 32'd0);
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    @(negedge clk);
    req_valid = 2'b01;
    req_a[0] = 32'd1;
    req_b[0] = 32'd1;
    txn(0, 32'd2, 1'b0, 1'b0);
    req_valid = 2'b11;
    #1 chk("rr_after_p0", 32'(req_ready), 32'd2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_issue_valid", 32'(rsp_valid), 32'd0);
    chk("rst_issue_out", rsp_out, 32'd0);
    chk("rst_issue_alu", alu_a, 32'd0);
    #1 chk("rst_issue_grant", 32'(req_ready), 32'd1);
    repeat (2) @(negedge clk);
    chk("pre_rst_resp", 32'(rsp_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_resp_valid", 32'(rsp_valid), 32'd0);
    #1 chk("rst_resp_grant", 32'(req_ready), 32'd1);
    req_valid = 2'b00;
    @(negedge clk);
    chk("rst_resp_late", 32'(rsp_valid), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
